// File: rtl/fire_pkg.sv
// fire_pkg: shared constants and types for the fire expand OFM datapath
package fire_pkg;
  localparam int WIDTH = 16;
  localparam int CHOUT = 64;
  localparam int LANES = 4;
  typedef logic [WIDTH-1:0] ofm_word_t;
  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} wr_state_t;
endpackage

// File: rtl/fire_expand_ofm_writer.sv
// fire_expand_ofm_writer: captures a CHOUT-wide OFM vector per sample and drains it to RAM LANES words per beat
module fire_expand_ofm_writer
  import fire_pkg::*;
#(
  parameter int WOUT = 64,
  parameter int AW   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sample,
  input  ofm_word_t              ofm [0:CHOUT-1],
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [LANES*WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);
  localparam int BEATS = CHOUT / LANES;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PIX   = WOUT * WOUT;
  localparam int PW    = PIX > 1 ? $clog2(PIX) : 1;
  localparam int DW    = LANES * WIDTH;
  localparam int CW    = $clog2(CHOUT * WIDTH);
  wr_state_t state, state_n;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [PW-1:0] pix_cnt, pix_n;
  logic [CHOUT*WIDTH-1:0] cap, ofm_flat;
  logic [CW-1:0] base;
  logic ovr_n, cap_en, last_beat, last_pix;
  for (genvar i = 0; i < CHOUT; i++) begin : g_flat
    assign ofm_flat[i*WIDTH +: WIDTH] = ofm[i];
  end
  assign last_beat = beat_cnt == BW'(BEATS - 1);
  assign last_pix  = pix_cnt == PW'(PIX - 1);
  assign base      = CW'(beat_cnt) * CW'(DW);
  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    pix_n   = pix_cnt;
    ovr_n   = overrun;
    cap_en  = 1'b0;
    if (start) begin
      state_n = ARMED;
      beat_n  = '0;
      pix_n   = '0;
      ovr_n   = 1'b0;
    end else begin
      case (state)
        ARMED: begin
          state_n = sample ? DRAIN : ARMED;
          cap_en  = sample;
        end
        DRAIN: begin
          beat_n = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) begin
            pix_n   = pix_cnt + 1'b1;
            state_n = last_pix ? DONE : (sample ? DRAIN : ARMED);
            cap_en  = sample && !last_pix;
          end else if (sample) begin
            ovr_n = 1'b1;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  // Capture buffer carries no reset: its contents only matter after an accepted sample
  always_ff @(posedge clk)
    if (cap_en) cap <= ofm_flat;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      pix_cnt  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      pix_cnt  <= pix_n;
      overrun  <= ovr_n;
      busy     <= state_n == ARMED || state_n == DRAIN;
      done     <= state == DONE;
      wr_en    <= state == DRAIN;
      if (state == DRAIN) begin
        wr_addr <= AW'(pix_cnt) * AW'(BEATS) + AW'(beat_cnt);
        wr_data <= cap[base +: DW];
      end
    end
  end
endmodule
